// File: rtl/io_port_responder_pkg.sv
// Shared constants, status bit positions and FSM encodings for the I/O port responder.
// Helper packs the status byte so the bit layout lives in one place.
package io_port_responder_pkg;

  localparam logic [15:0] STS_ADDR_DFLT = 16'h0100;
  localparam logic [15:0] RBR_ADDR_DFLT = 16'h0101;
  localparam logic [15:0] OUT_ADDR_DFLT = 16'h0140;

  localparam int STS_FI   = 0;
  localparam int STS_FO   = 1;
  localparam int STS_BPTR = 2;
  localparam int STS_OVR  = 7;

  typedef enum logic [1:0] {
    I_IDLE = 2'd0,
    I_WDAV = 2'd1,
    I_WRD  = 2'd2
  } inState_t;

  typedef enum logic [1:0] {
    O_IDLE = 2'd0,
    O_PRES = 2'd1,
    O_WRFD = 2'd2
  } outState_t;

  function automatic logic [7:0] packStatus(input logic ovr, input logic bptr,
                                            input logic fo, input logic fi);
    logic [7:0] s;
    s           = 8'h00;
    s[STS_OVR]  = ovr;
    s[STS_BPTR] = bptr;
    s[STS_FO]   = fo;
    s[STS_FI]   = fi;
    return s;
  endfunction

endpackage

// File: rtl/io_port_responder_strobe_edge.sv
// Registers the bus strobes and flags the cycle in which each one rises.
// A write strobe that overlapped a read strobe never reports completion.
module io_strobe_edge (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_ior_,
  input  logic i_iow_,
  output logic o_rdDone,
  output logic o_wrDone
);

  logic r_iorQ;
  logic r_iowQ;
  logic r_collide;

  // The collision flag lives for the whole low phase of iow_ and clears once it is high again.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_iorQ    <= 1'b1;
      r_iowQ    <= 1'b1;
      r_collide <= 1'b0;
    end else begin
      r_iorQ <= i_ior_;
      r_iowQ <= i_iow_;
      if (i_iow_)
        r_collide <= 1'b0;
      else if (!i_ior_)
        r_collide <= 1'b1;
    end
  end

  assign o_rdDone = !r_iorQ && i_ior_;
  assign o_wrDone = !r_iowQ && i_iow_ && !r_collide;

endmodule

// File: rtl/io_port_responder.sv
// Bus-side responder: a producer-fed status/receive register pair and a two-byte
// output word handed to a consumer, both reachable over one addr/data/ior_/iow_ bus.
module io_port_responder
  import io_port_responder_pkg::*;
#(
  parameter logic [15:0] STS_ADDR = STS_ADDR_DFLT,
  parameter logic [15:0] RBR_ADDR = RBR_ADDR_DFLT,
  parameter logic [15:0] OUT_ADDR = OUT_ADDR_DFLT
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic [15:0] addr,
  inout  wire  [7:0]  data,
  input  logic        ior_,
  input  logic        iow_,
  input  logic [7:0]  in_data,
  input  logic        in_dav_,
  output logic        in_rfd,
  output logic [15:0] out_word,
  output logic        out_dav_,
  input  logic        out_rfd
);

  logic      w_rdDone;
  logic      w_wrDone;
  logic      w_commit;
  logic      w_rdEn;
  logic [7:0] w_rdData;
  logic [7:0] w_status;

  logic [7:0] r_rbr;
  logic       r_fi;
  logic       r_bptr;
  logic       r_ovr;
  logic [7:0] r_msb;
  logic [7:0] r_wStage;
  inState_t   r_inState;
  outState_t  r_outState;

  io_strobe_edge u_strobeEdge (
    .i_clock  (clock),
    .i_reset  (reset_),
    .i_ior_   (ior_),
    .i_iow_   (iow_),
    .o_rdDone (w_rdDone),
    .o_wrDone (w_wrDone)
  );

  assign w_commit = w_wrDone && (addr == OUT_ADDR);
  assign w_status = packStatus(r_ovr, r_bptr, r_outState == O_IDLE, r_fi);

  // Read data is served combinationally for the whole low phase of ior_.
  always_comb begin
    w_rdEn   = 1'b0;
    w_rdData = 8'h00;
    if (!ior_) begin
      if (addr == STS_ADDR) begin
        w_rdEn   = 1'b1;
        w_rdData = w_status;
      end else if (addr == RBR_ADDR) begin
        w_rdEn   = 1'b1;
        w_rdData = r_rbr;
      end
    end
  end

  assign data = w_rdEn ? w_rdData : 8'bz;

  always_ff @(posedge clock) begin
    if (reset_)
      r_wStage <= 8'h00;
    else if (!iow_ && (addr == OUT_ADDR))
      r_wStage <= data;
  end

  // Input side: a set from the producer wins over a read-side clear of FI.
  always_ff @(posedge clock) begin
    if (reset_) begin
      r_inState <= I_IDLE;
      in_rfd    <= 1'b1;
      r_rbr     <= 8'h00;
      r_fi      <= 1'b0;
    end else begin
      if (w_rdDone && (addr == RBR_ADDR))
        r_fi <= 1'b0;
      case (r_inState)
        I_IDLE: begin
          if (!in_dav_) begin
            r_rbr     <= in_data;
            r_fi      <= 1'b1;
            in_rfd    <= 1'b0;
            r_inState <= I_WDAV;
          end
        end
        I_WDAV: begin
          if (in_dav_)
            r_inState <= I_WRD;
        end
        I_WRD: begin
          if (!r_fi) begin
            in_rfd    <= 1'b1;
            r_inState <= I_IDLE;
          end
        end
        default: begin
          in_rfd    <= 1'b1;
          r_inState <= I_IDLE;
        end
      endcase
    end
  end

  // Output side: a commit arriving while a word is still outstanding is lost and flagged.
  always_ff @(posedge clock) begin
    if (reset_) begin
      r_outState <= O_IDLE;
      out_dav_   <= 1'b1;
      out_word   <= 16'h0000;
      r_msb      <= 8'h00;
      r_bptr     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      if (w_rdDone && (addr == STS_ADDR))
        r_ovr <= 1'b0;
      if (w_commit && (r_outState != O_IDLE))
        r_ovr <= 1'b1;
      case (r_outState)
        O_IDLE: begin
          if (w_commit) begin
            if (!r_bptr) begin
              r_msb  <= r_wStage;
              r_bptr <= 1'b1;
            end else begin
              out_word   <= {r_msb, r_wStage};
              r_bptr     <= 1'b0;
              out_dav_   <= 1'b0;
              r_outState <= O_PRES;
            end
          end
        end
        O_PRES: begin
          if (!out_rfd) begin
            out_dav_   <= 1'b1;
            r_outState <= O_WRFD;
          end
        end
        O_WRFD: begin
          if (out_rfd)
            r_outState <= O_IDLE;
        end
        default: begin
          out_dav_   <= 1'b1;
          r_outState <= O_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/io_port_responder.md
Name: io_port_responder

Overview:
- Bus-side responder for the initiator's addr/data/ior_/iow_ I/O protocol.
- Combines two interfaces behind one bus connection:
  - an input interface: a status register and a receive buffer, loaded from a producer through a dav_/rfd handshake;
  - an output interface: a 16-bit word written MSB then LSB, handed to a consumer through a dav_/rfd handshake.

Parameters:
- STS_ADDR, 16'h0100, status register (read-only).
- RBR_ADDR, 16'h0101, receive buffer register (read-only).
- OUT_ADDR, 16'h0140, output word register (write-only, two bytes).

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset_  in  1  synchronous, active-high reset.
- addr  in  16  bus address from the initiator.
- data  inout  8  bus data; driven only during a decoded read, else high-Z.
- ior_  in  1  read strobe, active low.
- iow_  in  1  write strobe, active low.
- in_data  in  8  producer byte.
- in_dav_  in  1  producer data valid, active low.
- in_rfd  out  1  ready for data to the producer.
- out_word  out  16  word presented to the consumer.
- out_dav_  out  1  output data valid, active low.
- out_rfd  in  1  consumer ready for data.

Behaviour:
- Reset values: in_rfd=1, out_dav_=1, out_word=0, RBR=0, FI=0, BPTR=0, OVR=0, both FSMs idle, ior_q=iow_q=1, data high-Z.
- Status byte read at STS_ADDR = {OVR,4'b0,BPTR,FO,FI}.
  - FO=1 iff OUT FSM is O_IDLE.
  - BPTR=1 means the MSB is held and the LSB is expected next.
- Read path:
  - data is driven combinationally while ior_==0 and addr is STS_ADDR or RBR_ADDR; zero added latency.
  - ior_q and iow_q are one-cycle registered copies of the strobes.
  - A read completes on a rising strobe (ior_q==0 && ior_==1).
  - Completing a read of RBR_ADDR clears FI. Completing a read of STS_ADDR clears OVR.
  - The address is decoded in the completion cycle; the initiator holds addr through the strobe rise.
- Write path:
  - Every clock with iow_==0 and addr==OUT_ADDR latches data into WSTAGE.
  - Commit happens on iow_ rise (iow_q==0 && iow_==1) with addr==OUT_ADDR, only if OUT FSM is O_IDLE:
    - BPTR==0: MSB<=WSTAGE, BPTR<=1;
    - BPTR==1: out_word<={MSB,WSTAGE}, BPTR<=0, OUT FSM->O_PRES.
  - A commit while OUT FSM is not O_IDLE is dropped and sets OVR.
  - Writes to any other address are ignored.
- IN FSM:
  - I_IDLE (in_rfd=1): in_dav_==0 -> RBR<=in_data, FI<=1, in_rfd<=0, ->I_WDAV.
  - I_WDAV: in_dav_==1 -> I_WRD.
  - I_WRD: FI==0 -> I_IDLE, in_rfd<=1.
- OUT FSM:
  - O_IDLE: entered/left as described under Write path.
  - O_PRES: out_dav_=0; out_rfd==0 -> out_dav_<=1, ->O_WRFD.
  - O_WRFD: out_rfd==1 -> O_IDLE.
- Boundaries:
  - An RBR read completing in the same cycle the IN FSM enters I_WRD: FI=0 seen next cycle; in_rfd rises one cycle later.
  - ior_ and iow_ both low is a protocol error: the read is served, the write commit is suppressed.
  - Reset mid-transfer discards MSB/BPTR and any pending word; out_dav_ returns to 1 in the same reset cycle.
  - Reads of unmapped addresses leave data high-Z.

Decomposition:
- Shared package: address constants, status bit indices (FI=0, FO=1, BPTR=2, OVR=7), IN/OUT state encodings.
- Natural sub-module: io_strobe_edge. It registers ior_/iow_ and emits rd_done/wr_done pulses.

Test Plan:
- Reset with reset_=1 for 2 cycles -> in_rfd=1, out_dav_=1, status read returns 8'h02, data high-Z when idle.
- Producer drives in_data=8'hA5 with in_dav_ pulsed low -> in_rfd=0, status=8'h03. Bus reads RBR -> returns 8'hA5, FI=0, in_rfd=1 within 2 cycles of ior_ rise.
- Writes of 8'h12 then 8'h34 to 16'h0140 -> status bit2 =1 after the first write; out_word=16'h1234 and out_dav_=0 after the second. out_rfd pulsed low then high -> out_dav_=1, FO=1.
- Third write while out_dav_=0 -> status reads 8'h80 with FO=0, out_word unchanged. A second status read -> OVR cleared.
- Reset asserted after the MSB write only -> BPTR=0. Writes of 8'hBE, 8'hEF -> out_word=16'hBEEF.
- ior_=iow_=0 together at OUT_ADDR -> no commit, BPTR unchanged.
